// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, runs a single-outstanding req/gnt/rvalid fetch, buffers {pc,instr} in a 2-entry FIFO.
// Latency: grant->new PC next cycle, response->head valid next cycle; decode backpressure fills the FIFO, then requests stop.
// FETCH_MISALIGN_TRAP_EN: misaligned fetch PC pushes a NOP marker entry instead of requesting memory.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] pc_next_in,
  input  logic        flush_in,
  output logic [31:0] fetch_pc_out,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_gnt_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        misalign_out,
  input  logic        id_ready_in
);

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        mis;
  } ent_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        req_q, req_d;
  logic        trap_q, trap_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        vld_q, vld_d;
  ent_t        head_q, head_d;
  ent_t        tail_q, tail_d;

  logic        push, pop, room, outstanding;
  ent_t        push_ent;

  function automatic logic pc_mis(input logic [31:0] pc);
    return TRAP_EN && (pc[1:0] != 2'b00);
  endfunction

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    trap_d      = trap_q;
    push        = 1'b0;
    push_ent    = '{pc: req_pc_q, ins: imem_rdata_in, mis: 1'b0};
    pop         = vld_q && id_ready_in && !flush_in;
    // Free slot after this cycle's push, given the current pop.
    room        = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop);
    outstanding = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pc_mis(fetch_pc_q)) begin
          if (!trap_q && ((cnt_q != 2'd2) || pop)) begin
            push     = 1'b1;
            push_ent = '{pc: fetch_pc_q, ins: NOP_INSTR, mis: 1'b1};
            trap_d   = 1'b1;
          end
        end else if (cnt_q != 2'd2) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_gnt_in) begin
          fetch_pc_d = pc_next_in;
          req_pc_d   = fetch_pc_q;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_in) begin
          push    = 1'b1;
          state_d = (room && !pc_mis(fetch_pc_q)) ? S_REQ : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid_in) begin
          state_d = pc_mis(fetch_pc_q) ? S_IDLE : S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides everything; a response landing this cycle belongs to the old path.
    if (flush_in) begin
      fetch_pc_d  = pc_next_in;
      push        = 1'b0;
      trap_d      = 1'b0;
      outstanding = (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_rvalid_in) ||
                    ((state_q == S_REQ) && imem_gnt_in);
      if (outstanding) begin
        state_d = S_DRAIN;
      end else begin
        state_d = pc_mis(pc_next_in) ? S_IDLE : S_REQ;
      end
    end

    req_d = (state_d == S_REQ);
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush_in) begin
      cnt_d = 2'd0;
    end else if (pop && push) begin
      if (cnt_q == 2'd2) begin
        head_d = tail_q;
        tail_d = push_ent;
      end else begin
        head_d = push_ent;
      end
    end else if (pop) begin
      head_d = tail_q;
      cnt_d  = cnt_q - 2'd1;
    end else if (push) begin
      if (cnt_q == 2'd0) begin
        head_d = push_ent;
      end else begin
        tail_d = push_ent;
      end
      cnt_d = cnt_q + 2'd1;
    end
    vld_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      req_q      <= 1'b0;
      trap_q     <= 1'b0;
      cnt_q      <= 2'd0;
      vld_q      <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      req_q      <= req_d;
      trap_q     <= trap_d;
      cnt_q      <= cnt_d;
      vld_q      <= vld_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign fetch_pc_out    = fetch_pc_q;
  assign imem_req_out    = req_q;
  assign instr_valid_out = vld_q;
  assign instr_out       = head_q.ins;
  assign instr_pc_out    = head_q.pc;
  assign misalign_out    = head_q.mis;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign imem_addr_out = fetch_pc_q;
`else
  assign imem_addr_out = {fetch_pc_q[31:2], 2'b00};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: auto-responding memory for streaming, manual gnt/rvalid for flush and reset corners.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_in;
  logic        flush_in;
  logic [31:0] flush_tgt;
  logic        id_ready_in;
  logic        mem_auto;
  logic        man_gnt, man_rvalid;
  logic [31:0] man_rdata;
  logic        auto_gnt, auto_rvalid;
  logic [31:0] auto_rdata;
  logic        pend;
  logic [31:0] pend_addr;

  logic [31:0] pc_next_in, fetch_pc_out, imem_addr_out, imem_rdata_in;
  logic [31:0] instr_out, instr_pc_out;
  logic        imem_req_out, imem_gnt_in, imem_rvalid_in, instr_valid_out, misalign_out;

  int          n_chk = 0;
  int          n_bad = 0;
  int          cyc_cnt = 0;
  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];
  int          q_cyc[$];
  logic [31:0] last_pc;

  always #5 clk = ~clk;

  assign pc_next_in     = flush_in ? flush_tgt : fetch_pc_out + 32'd4;
  assign imem_gnt_in    = mem_auto ? auto_gnt : man_gnt;
  assign imem_rvalid_in = mem_auto ? auto_rvalid : man_rvalid;
  assign imem_rdata_in  = mem_auto ? auto_rdata : man_rdata;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in(clk), .rst_in(rst_in), .pc_next_in(pc_next_in), .flush_in(flush_in),
    .fetch_pc_out(fetch_pc_out), .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_gnt_in(imem_gnt_in), .imem_rvalid_in(imem_rvalid_in), .imem_rdata_in(imem_rdata_in),
    .instr_valid_out(instr_valid_out), .instr_out(instr_out), .instr_pc_out(instr_pc_out),
    .misalign_out(misalign_out), .id_ready_in(id_ready_in)
  );

  // Memory that grants immediately and answers the following cycle; word = C0DE_<addr[15:0]>.
  always @(posedge clk) begin
    cyc_cnt   <= cyc_cnt + 1;
    pend      <= !rst_in && imem_req_out && imem_gnt_in;
    pend_addr <= imem_addr_out;
  end

  always @(negedge clk) begin
    auto_gnt    = imem_req_out;
    auto_rvalid = pend;
    auto_rdata  = 32'hC0DE_0000 | {16'h0000, pend_addr[15:0]};
  end

  always @(negedge clk) begin
    #2;
    if (!rst_in && instr_valid_out && id_ready_in && !flush_in) begin
      q_pc.push_back(instr_pc_out);
      q_ins.push_back(instr_out);
      q_cyc.push_back(cyc_cnt);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic clr_q();
    q_pc.delete();
    q_ins.delete();
    q_cyc.delete();
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k = 0;
    while (q_pc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (q_pc.size() < n) chk("pop_timeout", 32'(q_pc.size()), 32'(n));
  endtask

  // Park the DUT in REQ with nothing outstanding, then hand the memory side to manual control.
  task automatic to_manual();
    int k = 0;
    while (!imem_req_out && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!imem_req_out) chk("req_timeout", {31'd0, imem_req_out}, 32'd1);
    mem_auto = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; flush_in = 1'b0; flush_tgt = '0; id_ready_in = 1'b1;
    mem_auto = 1'b1; man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
    auto_gnt = 1'b0; auto_rvalid = 1'b0; auto_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pc",   fetch_pc_out, 32'h0);
    chk("rst_req",  {31'd0, imem_req_out}, 32'd0);
    chk("rst_addr", imem_addr_out, 32'h0);
    chk("rst_vld",  {31'd0, instr_valid_out}, 32'd0);
    chk("rst_ins",  instr_out, 32'h0);
    chk("rst_ipc",  instr_pc_out, 32'h0);
    chk("rst_mis",  {31'd0, misalign_out}, 32'd0);

    // Streaming: 0, 4, 8 one every 2 cycles
    rst_in = 1'b0;
    clr_q();
    wait_pops(3, 40);
    chk("s_pc0",  q_pc[0], 32'h0);
    chk("s_pc1",  q_pc[1], 32'h4);
    chk("s_pc2",  q_pc[2], 32'h8);
    chk("s_ins0", q_ins[0], 32'hC0DE_0000);
    chk("s_ins2", q_ins[2], 32'hC0DE_0008);
    chk("s_gap1", 32'(q_cyc[1] - q_cyc[0]), 32'd2);
    chk("s_gap2", 32'(q_cyc[2] - q_cyc[1]), 32'd2);

    // Decode stall: FIFO fills to 2 and requests stop
    @(negedge clk);
    id_ready_in = 1'b0;
    last_pc = q_pc[q_pc.size()-1];
    clr_q();
    repeat (10) @(negedge clk);
    chk("st_vld", {31'd0, instr_valid_out}, 32'd1);
    chk("st_req", {31'd0, imem_req_out}, 32'd0);
    chk("st_hpc", instr_pc_out, last_pc + 32'd4);
    id_ready_in = 1'b1;
    wait_pops(4, 40);
    chk("st_p0", q_pc[0], last_pc + 32'd4);
    chk("st_p1", q_pc[1], last_pc + 32'd8);
    chk("st_p2", q_pc[2], last_pc + 32'd12);
    chk("st_p3", q_pc[3], last_pc + 32'd16);
    chk("st_b2b", 32'(q_cyc[1] - q_cyc[0]), 32'd1);

    // Flush while WAIT
    to_manual();
    man_gnt = 1'b1;
    @(negedge clk);
    man_gnt = 1'b0;
    chk("fw_wait_req", {31'd0, imem_req_out}, 32'd0);
    flush_in = 1'b1; flush_tgt = 32'h100;
    clr_q();
    @(negedge clk);
    flush_in = 1'b0;
    chk("fw_pc",  fetch_pc_out, 32'h100);
    chk("fw_vld", {31'd0, instr_valid_out}, 32'd0);
    chk("fw_drain_req", {31'd0, imem_req_out}, 32'd0);
    man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    man_rvalid = 1'b0;
    chk("fw_req",  {31'd0, imem_req_out}, 32'd1);
    chk("fw_addr", imem_addr_out, 32'h100);
    chk("fw_vld2", {31'd0, instr_valid_out}, 32'd0);
    mem_auto = 1'b1;
    clr_q();
    wait_pops(2, 40);
    chk("fw_h0",   q_pc[0], 32'h100);
    chk("fw_ins0", q_ins[0], 32'hC0DE_0100);
    chk("fw_h1",   q_pc[1], 32'h104);

    // Flush coincident with grant
    to_manual();
    flush_in = 1'b1; flush_tgt = 32'h200; man_gnt = 1'b1;
    @(negedge clk);
    flush_in = 1'b0; man_gnt = 1'b0;
    chk("fg_req", {31'd0, imem_req_out}, 32'd0);
    chk("fg_vld", {31'd0, instr_valid_out}, 32'd0);
    chk("fg_pc",  fetch_pc_out, 32'h200);
    man_rvalid = 1'b1; man_rdata = 32'hBAD0_0001;
    @(negedge clk);
    man_rvalid = 1'b0;
    chk("fg_req2", {31'd0, imem_req_out}, 32'd1);
    chk("fg_addr", imem_addr_out, 32'h200);
    chk("fg_vld2", {31'd0, instr_valid_out}, 32'd0);

    // Flush coincident with response
    man_gnt = 1'b1;
    @(negedge clk);
    man_gnt = 1'b0;
    man_rvalid = 1'b1; man_rdata = 32'hBAD0_0002;
    flush_in = 1'b1; flush_tgt = 32'h300;
    @(negedge clk);
    man_rvalid = 1'b0; flush_in = 1'b0;
    chk("fr_vld",  {31'd0, instr_valid_out}, 32'd0);
    chk("fr_req",  {31'd0, imem_req_out}, 32'd1);
    chk("fr_addr", imem_addr_out, 32'h300);
    mem_auto = 1'b1;
    clr_q();
    wait_pops(1, 40);
    chk("fr_h0",   q_pc[0], 32'h300);
    chk("fr_ins0", q_ins[0], 32'hC0DE_0300);

    // Reset during WAIT, then a stray response
    to_manual();
    man_gnt = 1'b1;
    @(negedge clk);
    man_gnt = 1'b0;
    rst_in = 1'b1;
    #1;
    chk("rw_pc",  fetch_pc_out, 32'h0);
    chk("rw_req", {31'd0, imem_req_out}, 32'd0);
    chk("rw_vld", {31'd0, instr_valid_out}, 32'd0);
    chk("rw_ins", instr_out, 32'h0);
    chk("rw_ipc", instr_pc_out, 32'h0);
    @(negedge clk);
    rst_in = 1'b0;
    man_rvalid = 1'b1; man_rdata = 32'hBAD0_0003;
    @(negedge clk);
    man_rvalid = 1'b0;
    chk("rw_vld2", {31'd0, instr_valid_out}, 32'd0);
    chk("rw_req2", {31'd0, imem_req_out}, 32'd1);
    chk("rw_addr", imem_addr_out, 32'h0);
    @(negedge clk);
    chk("rw_vld3", {31'd0, instr_valid_out}, 32'd0);

    // PC wrap at the top of the address space
    flush_in = 1'b1; flush_tgt = 32'hFFFF_FFFC;
    @(negedge clk);
    flush_in = 1'b0;
    mem_auto = 1'b1;
    clr_q();
    wait_pops(2, 40);
    chk("wr_p0",  q_pc[0], 32'hFFFF_FFFC);
    chk("wr_ins", q_ins[0], 32'hC0DE_FFFC);
    chk("wr_p1",  q_pc[1], 32'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned target: marker entry, no request until redirected
    to_manual();
    id_ready_in = 1'b0;
    flush_in = 1'b1; flush_tgt = 32'h102;
    @(negedge clk);
    flush_in = 1'b0;
    chk("ma_req",  {31'd0, imem_req_out}, 32'd0);
    chk("ma_addr", imem_addr_out, 32'h102);
    @(negedge clk);
    chk("ma_vld", {31'd0, instr_valid_out}, 32'd1);
    chk("ma_pc",  instr_pc_out, 32'h102);
    chk("ma_ins", instr_out, 32'h0000_0013);
    chk("ma_mis", {31'd0, misalign_out}, 32'd1);
    chk("ma_req2", {31'd0, imem_req_out}, 32'd0);
    id_ready_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("ma_vld2", {31'd0, instr_valid_out}, 32'd0);
    chk("ma_req3", {31'd0, imem_req_out}, 32'd0);
    flush_in = 1'b1; flush_tgt = 32'h200;
    @(negedge clk);
    flush_in = 1'b0;
    chk("ma_req4",  {31'd0, imem_req_out}, 32'd1);
    chk("ma_addr2", imem_addr_out, 32'h200);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly downstream of the PC mux. Holds the architectural fetch PC, feeds it back to the mux as its `pc_in`, and loads the mux's next-PC output when instruction memory accepts a request. Runs a one-outstanding request/grant/response handshake with instruction memory and buffers returned instructions, with their PCs, in a 2-entry FIFO. Decode drains the FIFO through a valid/ready handshake.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC after reset (matches the mux's reset/`pc_src`=00 target).
- `clk_in`  in  1: clock, rising edge.
- `rst_in`  in  1: asynchronous, active-high reset.
- `pc_next_in`  in  32: next PC from the PC mux (`pc_mux_out`).
- `flush_in`  in  1: redirect; `pc_next_in` is a branch/jump target this cycle.
- `fetch_pc_out`  out  32: current fetch PC, to the mux `pc_in`.
- `imem_req_out`  out  1: request valid.
- `imem_addr_out`  out  32: request address.
- `imem_gnt_in`  in  1: request accepted this cycle.
- `imem_rvalid_in`  in  1: response valid.
- `imem_rdata_in`  in  32: instruction word.
- `instr_valid_out`  out  1: FIFO head valid.
- `instr_out`  out  32: head instruction.
- `instr_pc_out`  out  32: head PC.
- `misalign_out`  out  1: head entry is a misaligned-fetch marker.
- `id_ready_in`  in  1: decode accepts head.

## Operation
- Reset values: `fetch_pc_out`=RESET_PC, `imem_req_out`=0, `imem_addr_out`=RESET_PC, `instr_valid_out`=0, `instr_out`=0, `instr_pc_out`=0, `misalign_out`=0, FIFO empty, FSM=IDLE.
- `imem_addr_out`=`fetch_pc_out` at all times (see Configuration for bits [1:0]).
- FSM states:
  - IDLE: no request. Goes to REQ when FIFO count + outstanding < 2.
  - REQ: `imem_req_out`=1. On `imem_gnt_in`: `fetch_pc` <= `pc_next_in`, go to WAIT. Request may be withdrawn only by flush.
  - WAIT: one request outstanding. On `imem_rvalid_in`: push {`fetch_pc` of that request, `imem_rdata_in`}, then go to REQ if space remains, else IDLE.
  - DRAIN: outstanding response is discarded on arrival, then go to REQ.
- Captured request PC is registered at grant and tagged to the pushed entry.
- Space reservation: a request is issued only if an entry is free after counting the outstanding response, so a push never overflows.
- FIFO: 2 entries, registered head. Pop when `instr_valid_out` && `id_ready_in`. Push and pop in the same cycle are allowed at any count.
- Flush (highest priority, any state):
  - FIFO cleared; a same-cycle pop is void.
  - `fetch_pc` <= `pc_next_in`.
  - If a response is outstanding, or the grant lands in the flush cycle, go to DRAIN. Otherwise go to REQ.
  - A response arriving in the flush cycle is discarded.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Reset asserted mid-transaction returns everything to reset values immediately. A late `imem_rvalid_in` after reset is ignored, because the FSM is in IDLE/REQ.

## Timing
- Grant in cycle n → `fetch_pc_out` shows the new PC in cycle n+1.
- Earliest response is cycle n+1. The entry is visible on `instr_valid_out` in the cycle after the push.
- Best-case throughput is 1 instruction per 2 cycles (REQ, WAIT), because only one request is outstanding. The FIFO absorbs decode stalls.
- Flush in cycle f → new-target request at cycle f+1 (no outstanding response) or after the drain.
- All outputs are registered except `imem_addr_out`, which is a wire from the `fetch_pc` register.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - If `fetch_pc[1:0]`≠0 in IDLE/REQ, no request is issued.
  - Instead, once space is available, push one entry {pc=`fetch_pc`, instr=32'h0000_0013, misalign=1}.
  - The FSM then stays in IDLE until `flush_in`.
- Undefined:
  - `imem_addr_out[1:0]` is forced to 2'b00.
  - `misalign_out` is tied to 0.
  - The marker logic is absent.

## Test plan
- Reset, memory with 1-cycle grant and 1-cycle response, `pc_next_in`=`fetch_pc_out`+4, `id_ready_in`=1 → instructions at PCs 0x0, 0x4, 0x8 appear in order, one every 2 cycles.
- `id_ready_in`=0 for 10 cycles → exactly 2 entries buffered, `imem_req_out`=0, no lost or duplicated PC after release.
- Flush while WAIT with `pc_next_in`=0x100 → stale response discarded, FIFO empty, next head PC=0x100.
- Flush coincident with `imem_gnt_in` and with `imem_rvalid_in` → neither response is pushed, next head PC is the flush target.
- Reset asserted during WAIT, then a stray `imem_rvalid_in` → all outputs at reset values, FIFO stays empty, first request addr=RESET_PC.
- With `FETCH_MISALIGN_TRAP_EN`, flush to 0x102 → no request; head {pc=0x102, instr=0x00000013, misalign=1}; fetch resumes only after flush to 0x200.
